mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter NUM_PAIRS, default 16, number of operand pairs processed per run (1..16).
REQ-002 Parameter OPND_BASE, default 0, byte address of the first operand byte.
REQ-003 Parameter PROD_BASE, default 64, byte address of the first product byte.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port req  input  1  level start request from host/bench.
REQ-007 Port done  output  1  run complete; all products written.
REQ-008 Port busy  output  1  high in READ, MUL and WRITE states.
REQ-009 Port mem_addr  output  8  byte address to data memory.
REQ-010 Port mem_rd_data  input  8  data memory read byte, combinational from mem_addr in the same cycle.
REQ-011 Port mem_wr_en  output  1  byte write strobe; memory writes on the rising edge when high.
REQ-012 Port mem_wr_data  output  8  byte to write at mem_addr.

Function
REQ-013 States SHALL be IDLE, READ, MUL, WRITE and DONE; the pair index j runs 0..NUM_PAIRS-1, and the byte/iteration counter is 2-bit in READ/WRITE and 4-bit in MUL.
REQ-014 IDLE: IDLE->READ on the edge where req=1, with j=0 and cnt=0; otherwise hold.
REQ-015 READ lasts exactly 4 cycles: mem_addr=OPND_BASE+4j+cnt, and mem_rd_data is latched each edge.
REQ-016 Operand A={byte(4j), byte(4j+1)} and operand B={byte(4j+2), byte(4j+3)}; both are big-endian, 16-bit two's complement.
REQ-017 MUL lasts exactly 16 cycles using any iterative algorithm (shift-add with sign fix or radix-2 Booth), producing P=B*A as a signed 32-bit value, exact for all inputs.
REQ-018 WRITE lasts exactly 4 cycles: mem_wr_en=1, mem_addr=PROD_BASE+4j+cnt, and mem_wr_data=P[31:24], P[23:16], P[15:8], P[7:0] for cnt=0..3.
REQ-019 After WRITE cnt=3: if j<NUM_PAIRS-1, go to READ with j+1; else go to DONE.
REQ-020 Each pair SHALL take exactly 24 cycles, and done SHALL rise exactly 24*NUM_PAIRS cycles after the edge that sampled req=1 in IDLE (384 cycles for the default).
REQ-021 DONE: done=1 and busy=0, held while req=1; DONE->IDLE on the first edge with req=0, and done falls on that edge.
REQ-022 req SHALL be ignored while busy; a held-high req does not restart the run after DONE until it has been seen low.
REQ-023 Outside WRITE: mem_wr_en=0, and mem_wr_data=0.
REQ-024 In IDLE and DONE, mem_addr=0.
REQ-025 No memory address outside [OPND_BASE, OPND_BASE+4*NUM_PAIRS-1] or [PROD_BASE, PROD_BASE+4*NUM_PAIRS-1] SHALL ever be driven while busy.
REQ-026 Boundary case: (-32768)*(-32768) SHALL yield 0x40000000.
REQ-027 Boundary case: (-32768)*32767 SHALL yield 0xC0008000.
REQ-028 Boundary case: any operand 0 SHALL yield 0x00000000.
REQ-029 Operand bytes SHALL be re-read from memory for every pair; no caching across runs.

Reset
REQ-030 reset=1 at an edge SHALL force state=IDLE, j=0, cnt=0, done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, and clear the product/operand registers.
REQ-031 reset has priority over req; reset mid-run SHALL abort at that edge with no further writes, leaving already-written product bytes untouched.
REQ-032 After reset is released, a new req=1 in IDLE SHALL start a fresh run from j=0.

Verification
REQ-033 Bytes 0..3 = 00 03 FF FB (A=3, B=-5), NUM_PAIRS=1, req=1 -> bytes 64..67 = FF FF FF F1, done high 24 cycles after the start edge.
REQ-034 Default 16 pairs including (-32768,-32768), (-32768,32767), (0,1234) and (-1,-1) -> all 16 products match a signed reference model, done at cycle 384, and bytes 0..63 are unchanged.
REQ-035 Assert reset at cycle 50 of a run -> done=0, mem_wr_en=0 from the next cycle; only the pair 0 and pair 1 product bytes written before cycle 50 remain; re-issue req -> full correct run.
REQ-036 Hold req=1 through DONE for 10 cycles -> done stays 1 and no restart occurs; drop req -> done=0 on the next edge; raise req -> new run with identical results.
REQ-037 Toggle req during a run -> no effect on timing or results, and the write address sequence is exactly 64..127 ascending.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequential signed 16x16 multiplier engine: fetches operand pairs from a byte memory,
// multiplies them with a 16-cycle shift-add loop and writes 32-bit big-endian products back.
module mul_seq_ctrl #(
    parameter int NUM_PAIRS = 16,
    parameter int OPND_BASE = 0,
    parameter int PROD_BASE = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       done,
    output logic       busy,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MUL,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] J_LAST = 4'(NUM_PAIRS - 1);
    localparam logic [7:0] OPND_B = 8'(OPND_BASE);
    localparam logic [7:0] PROD_B = 8'(PROD_BASE);

    state_t              state_q, state_d;
    logic [3:0]          j_q, j_d;
    logic [3:0]          cnt_q, cnt_d;
    logic signed [15:0]  mplier_q, mplier_d;
    logic signed [31:0]  mcand_q, mcand_d;
    logic signed [31:0]  prod_q, prod_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [7:0]          mem_addr_q, mem_addr_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic [7:0]          mem_wr_data_q, mem_wr_data_d;
    logic [7:0]          pair_off;

    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        cnt_d    = cnt_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_READ;
                    j_d     = 4'd0;
                    cnt_d   = 4'd0;
                end
            end
            S_READ: begin
                // Multiplier A is kept raw; multiplicand B is sign-extended to 32 bits.
                unique case (cnt_q[1:0])
                    2'd0: mplier_d[15:8] = mem_rd_data;
                    2'd1: mplier_d[7:0]  = mem_rd_data;
                    2'd2: mcand_d = {{16{mem_rd_data[7]}}, mem_rd_data, 8'h00};
                    default: mcand_d[7:0] = mem_rd_data;
                endcase
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = S_MUL;
                    cnt_d   = 4'd0;
                    prod_d  = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_MUL: begin
                // Bit 15 of A carries weight -2^15, so its partial product is subtracted.
                if (mplier_q[0]) begin
                    prod_d = (cnt_q == 4'd15) ? prod_q - mcand_q : prod_q + mcand_q;
                end
                mcand_d  = mcand_q <<< 1;
                mplier_d = mplier_q >>> 1;
                if (cnt_q == 4'd15) begin
                    state_d = S_WRITE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WRITE: begin
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d = 4'd0;
                    if (j_q == J_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        j_d     = j_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    always_comb begin
        pair_off      = {2'b00, j_d, 2'b00};
        busy_d        = (state_d == S_READ) || (state_d == S_MUL) || (state_d == S_WRITE);
        done_d        = (state_d == S_DONE);
        mem_wr_en_d   = (state_d == S_WRITE);
        mem_addr_d    = 8'h00;
        mem_wr_data_d = 8'h00;
        unique case (state_d)
            S_READ:  mem_addr_d = OPND_B + pair_off + {6'b0, cnt_d[1:0]};
            S_MUL:   mem_addr_d = OPND_B + pair_off;
            S_WRITE: begin
                mem_addr_d = PROD_B + pair_off + {6'b0, cnt_d[1:0]};
                unique case (cnt_d[1:0])
                    2'd0:    mem_wr_data_d = prod_d[31:24];
                    2'd1:    mem_wr_data_d = prod_d[23:16];
                    2'd2:    mem_wr_data_d = prod_d[15:8];
                    default: mem_wr_data_d = prod_d[7:0];
                endcase
            end
            default: mem_addr_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            j_q           <= '0;
            cnt_q         <= '0;
            mplier_q      <= '0;
            mcand_q       <= '0;
            prod_q        <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            j_q           <= j_d;
            cnt_q         <= cnt_d;
            mplier_q      <= mplier_d;
            mcand_q       <= mcand_d;
            prod_q        <= prod_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign done        = done_q;
    assign busy        = busy_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: a 16-pair instance and a 1-pair instance, each with
// its own byte memory model, checked against hand-computed products.
module tb_mul_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       done0, busy0, wr_en0, done1, busy1, wr_en1;
    logic [7:0] addr0, rd0, wdata0, addr1, rd1, wdata1;
    logic       load = 1'b0;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] img0 [256];
    logic [7:0] img1 [256];
    logic [15:0] opa [16];
    logic [15:0] opb [16];
    logic [31:0] expp [16];

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int order_err = 0;
    int bad_addr = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl dut0 (
        .clk(clk), .reset(reset), .req(req0), .done(done0), .busy(busy0),
        .mem_addr(addr0), .mem_rd_data(rd0), .mem_wr_en(wr_en0), .mem_wr_data(wdata0)
    );

    mul_seq_ctrl #(.NUM_PAIRS(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .done(done1), .busy(busy1),
        .mem_addr(addr1), .mem_rd_data(rd1), .mem_wr_en(wr_en1), .mem_wr_data(wdata1)
    );

    assign rd0 = mem0[addr0];
    assign rd1 = mem1[addr1];

    // Memory models plus write-order and address-range monitors for the 16-pair instance.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= img0[i];
                mem1[i] <= img1[i];
            end
            wr_cnt    <= 0;
            order_err <= 0;
            bad_addr  <= 0;
        end else begin
            if (wr_en0) begin
                mem0[addr0] <= wdata0;
                if (int'(addr0) != 64 + (wr_cnt % 64)) order_err <= order_err + 1;
                wr_cnt <= wr_cnt + 1;
            end
            if (busy0 && !(addr0 < 8'd64 || (addr0 >= 8'd64 && addr0 < 8'd128)))
                bad_addr <= bad_addr + 1;
            if (wr_en1) mem1[addr1] <= wdata1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load();
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Starts a run on dut0 and returns the cycles from the start edge until done is seen.
    task automatic run0(input bit toggle, output int cyc);
        req0 = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        if (toggle) req0 = 1'b0;
        while (!done0 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (toggle) req0 = cyc[0];
        end
    endtask

    task automatic check_products(input string tag);
        logic [31:0] w;
        int ok_src;
        for (int j = 0; j < 16; j++) begin
            w = {mem0[64+4*j], mem0[65+4*j], mem0[66+4*j], mem0[67+4*j]};
            chk($sformatf("%s_prod%0d", tag, j), w, expp[j]);
        end
        ok_src = 0;
        for (int i = 0; i < 64; i++) if (mem0[i] !== img0[i]) ok_src++;
        chk({tag, "_opnd_unchanged"}, 32'(ok_src), 32'd0);
    endtask

    initial begin
        int cyc;
        int stale;
        logic [31:0] w;

        opa[0]  = 16'h0003; opb[0]  = 16'hFFFB; expp[0]  = 32'hFFFFFFF1;
        opa[1]  = 16'h8000; opb[1]  = 16'h8000; expp[1]  = 32'h40000000;
        opa[2]  = 16'h8000; opb[2]  = 16'h7FFF; expp[2]  = 32'hC0008000;
        opa[3]  = 16'h0000; opb[3]  = 16'h04D2; expp[3]  = 32'h00000000;
        opa[4]  = 16'hFFFF; opb[4]  = 16'hFFFF; expp[4]  = 32'h00000001;
        opa[5]  = 16'h7FFF; opb[5]  = 16'h7FFF; expp[5]  = 32'h3FFF0001;
        opa[6]  = 16'h04D2; opb[6]  = 16'h0000; expp[6]  = 32'h00000000;
        opa[7]  = 16'h0064; opb[7]  = 16'hFF38; expp[7]  = 32'hFFFFB1E0;
        opa[8]  = 16'h0001; opb[8]  = 16'h7FFF; expp[8]  = 32'h00007FFF;
        opa[9]  = 16'hFFFF; opb[9]  = 16'h8000; expp[9]  = 32'h00008000;
        opa[10] = 16'h0100; opb[10] = 16'h0100; expp[10] = 32'h00010000;
        opa[11] = 16'h7FFF; opb[11] = 16'h8000; expp[11] = 32'hC0008000;
        opa[12] = 16'h1234; opb[12] = 16'h0010; expp[12] = 32'h00012340;
        opa[13] = 16'hFFFE; opb[13] = 16'h4000; expp[13] = 32'hFFFF8000;
        opa[14] = 16'h00FF; opb[14] = 16'hFF01; expp[14] = 32'hFFFF01FF;
        opa[15] = 16'h5555; opb[15] = 16'h0003; expp[15] = 32'h0000FFFF;

        for (int i = 0; i < 256; i++) begin
            img0[i] = 8'hAA;
            img1[i] = 8'hAA;
        end
        for (int j = 0; j < 16; j++) begin
            img0[4*j]   = opa[j][15:8];
            img0[4*j+1] = opa[j][7:0];
            img0[4*j+2] = opb[j][15:8];
            img0[4*j+3] = opb[j][7:0];
        end
        img1[0] = 8'h00; img1[1] = 8'h03; img1[2] = 8'hFF; img1[3] = 8'hFB;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_wr_en", 32'(wr_en0), 32'd0);
        chk("rst_wr_data", 32'(wdata0), 32'd0);
        reset = 1'b0;
        do_load();

        // Single pair: 3 * -5
        req1 = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        chk("one_busy", 32'(busy1), 32'd1);
        while (!done1 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("one_done_cycle", 32'(cyc), 32'd24);
        chk("one_busy_done", 32'(busy1), 32'd0);
        w = {mem1[64], mem1[65], mem1[66], mem1[67]};
        chk("one_prod", w, 32'hFFFFFFF1);
        req1 = 1'b0;
        @(posedge clk);
        #1;
        chk("one_done_fall", 32'(done1), 32'd0);

        // Full run with req toggling throughout
        run0(1'b1, cyc);
        chk("tog_done_cycle", 32'(cyc), 32'd384);
        chk("tog_wr_count", 32'(wr_cnt), 32'd64);
        chk("tog_wr_order", 32'(order_err), 32'd0);
        chk("tog_addr_range", 32'(bad_addr), 32'd0);
        check_products("tog");
        req0 = 1'b0;
        @(posedge clk);
        #1;
        chk("tog_idle_addr", 32'(addr0), 32'd0);

        // Hold req through DONE, then release and restart
        do_load();
        run0(1'b0, cyc);
        chk("hold_done_cycle", 32'(cyc), 32'd384);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold_done_%0d", k), 32'(done0), 32'd1);
            chk($sformatf("hold_busy_%0d", k), 32'(busy0), 32'd0);
        end
        chk("hold_no_rewrite", 32'(wr_cnt), 32'd64);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_done_fall", 32'(done0), 32'd0);
        do_load();
        run0(1'b0, cyc);
        chk("rerun_done_cycle", 32'(cyc), 32'd384);
        check_products("rerun");
        req0 = 1'b0;
        @(posedge clk);
        #1;

        // Reset at cycle 50 of a run
        do_load();
        req0 = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        req0 = 1'b0;
        while (cyc < 49) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_done", 32'(done0), 32'd0);
        chk("abort_wr_en", 32'(wr_en0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_addr", 32'(addr0), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_wr_count", 32'(wr_cnt), 32'd8);
        w = {mem0[64], mem0[65], mem0[66], mem0[67]};
        chk("abort_prod0", w, expp[0]);
        w = {mem0[68], mem0[69], mem0[70], mem0[71]};
        chk("abort_prod1", w, expp[1]);
        stale = 0;
        for (int i = 72; i < 128; i++) if (mem0[i] !== 8'hAA) stale++;
        chk("abort_untouched", 32'(stale), 32'd0);
        run0(1'b0, cyc);
        chk("post_abort_cycle", 32'(cyc), 32'd384);
        chk("post_abort_range", 32'(bad_addr), 32'd0);
        check_products("post_abort");
        req0 = 1'b0;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
